// File: rtl/ysyx_25020037_ifu.sv
// ysyx_25020037_ifu -- instruction fetch unit for the multi-cycle core.
//
// Holds the architectural PC and issues one read per instruction. The
// fetched word is presented to decode, and then the unit waits for
// write-back to return the next PC.
//
// Ports:
//   clk, rst              core clock, synchronous active-high reset
//   pc, inst, inst_fault  fetched instruction, its PC, and the fault flag
//   ifu_valid/idu_ready   handshake toward decode
//   wbu_valid/dnpc        next PC from write-back, accepted while ifu_ready
//   araddr/arvalid/arready        read address channel
//   rdata/rresp/rvalid/rready     read data channel
//
// Every handshake output is decoded from the state alone. This keeps
// each handshake output free of combinational paths from any input.
module ysyx_25020037_ifu #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_fault,
    output logic        ifu_valid,
    input  logic        idu_ready,
    input  logic        wbu_valid,
    input  logic [31:0] dnpc,
    output logic        ifu_ready,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_SEND,
        S_WAIT_PC
    } state_t;

    state_t state, state_nxt;

    logic ar_hs, r_hs, id_hs, wb_hs;

    assign ar_hs  = arvalid & arready;
    assign r_hs   = rvalid & rready;
    assign id_hs  = ifu_valid & idu_ready;
    assign wb_hs  = wbu_valid & ifu_ready;
    assign araddr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            inst       <= 32'h0;
            inst_fault <= 1'b0;
        end else begin
            state <= state_nxt;
            // r_hs and wb_hs already gate on state through rready/ifu_ready,
            // so strays on rvalid/wbu_valid in other states cannot land here.
            if (r_hs) begin
                inst       <= rdata;
                inst_fault <= (rresp != 2'b00);
            end
            if (wb_hs) begin
                pc <= dnpc;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        arvalid   = 1'b0;
        rready    = 1'b0;
        ifu_valid = 1'b0;
        ifu_ready = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_AR;
            end
            S_AR: begin
                arvalid = 1'b1;
                if (ar_hs) state_nxt = S_R;
            end
            S_R: begin
                rready = 1'b1;
                if (r_hs) state_nxt = S_SEND;
            end
            S_SEND: begin
                ifu_valid = 1'b1;
                if (id_hs) state_nxt = S_WAIT_PC;
            end
            S_WAIT_PC: begin
                ifu_ready = 1'b1;
                if (wb_hs) state_nxt = S_AR;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_25020037_ifu.sv
// Scoreboard bench for ysyx_25020037_ifu. Each read response that is driven
// pushes the expected {pc, inst, fault}. The entry is popped and compared
// when the decode handshake takes place.
module tb_ysyx_25020037_ifu;

    localparam logic [31:0] RST_PC = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, inst, araddr, dnpc, rdata;
    logic        inst_fault, ifu_valid, idu_ready, wbu_valid, ifu_ready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  rresp;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mpc;
    int          n_chk = 0;
    int          n_err = 0;

    ysyx_25020037_ifu #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .pc(pc), .inst(inst), .inst_fault(inst_fault),
        .ifu_valid(ifu_valid), .idu_ready(idu_ready),
        .wbu_valid(wbu_valid), .dnpc(dnpc), .ifu_ready(ifu_ready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // All driving and sampling happens on the negedge.
    task automatic fetch(input logic [31:0] word, input logic [1:0] resp,
                         input int ar_w, input int r_w, input int idu_w,
                         input logic [31:0] next_pc, input bit early_rv,
                         input bit stray_wbu);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (arvalid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("ar_timeout", 32'd0, 32'd1);
            return;
        end
        chk("araddr", araddr, mpc);
        for (int i = 0; i < ar_w; i++) begin
            @(negedge clk);
            chk("ar_hold", 32'(arvalid), 32'd1);
            chk("ar_pc", araddr, mpc);
        end
        arready = 1'b1;
        if (early_rv) begin
            // Data offered alongside the address must not be taken.
            rvalid = 1'b1;
            rdata  = 32'hBAD0_BAD0;
            rresp  = 2'b00;
        end
        @(negedge clk);
        arready = 1'b0;
        rvalid  = 1'b0;
        chk("r_rready", 32'(rready), 32'd1);
        chk("r_novld", 32'(ifu_valid), 32'd0);
        chk("r_arvalid", 32'(arvalid), 32'd0);
        for (int i = 0; i < r_w; i++) begin
            if (stray_wbu && i == 0) begin
                wbu_valid = 1'b1;
                dnpc      = 32'h1234_5678;
            end
            @(negedge clk);
            wbu_valid = 1'b0;
            chk("r_hold", 32'(rready), 32'd1);
            chk("r_pc", pc, mpc);
        end
        rvalid = 1'b1;
        rdata  = word;
        rresp  = resp;
        sb.push_back('{pc: mpc, inst: word, fault: (resp != 2'b00)});
        @(negedge clk);
        rvalid = 1'b0;
        rdata  = 32'h0;
        rresp  = 2'b00;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
            return;
        end
        e = sb[0];
        chk("send_vld", 32'(ifu_valid), 32'd1);
        chk("send_rready", 32'(rready), 32'd0);
        for (int i = 0; i < idu_w; i++) begin
            @(negedge clk);
            chk("stall_vld", 32'(ifu_valid), 32'd1);
            chk("stall_inst", inst, e.inst);
            chk("stall_pc", pc, e.pc);
        end
        idu_ready = 1'b1;
        e = sb.pop_front();
        chk("hs_inst", inst, e.inst);
        chk("hs_pc", pc, e.pc);
        chk("hs_fault", 32'(inst_fault), 32'(e.fault));
        @(negedge clk);
        idu_ready = 1'b0;
        chk("wait_rdy", 32'(ifu_ready), 32'd1);
        chk("wait_novld", 32'(ifu_valid), 32'd0);
        chk("wait_pc", pc, mpc);
        wbu_valid = 1'b1;
        dnpc      = next_pc;
        @(negedge clk);
        wbu_valid = 1'b0;
        mpc       = next_pc;
        // Best case: the next AR comes right after the dnpc handshake.
        chk("next_ar", 32'(arvalid), 32'd1);
        chk("next_addr", araddr, next_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; idu_ready = 1'b0; wbu_valid = 1'b0; dnpc = 32'h0;
        arready = 1'b0; rdata = 32'h0; rresp = 2'b00; rvalid = 1'b0;
        mpc = RST_PC;
        repeat (3) @(negedge clk);
        chk("rst_pc", pc, RST_PC);
        chk("rst_inst", inst, 32'h0);
        chk("rst_fault", 32'(inst_fault), 32'd0);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_ifu_valid", 32'(ifu_valid), 32'd0);
        chk("rst_ifu_ready", 32'(ifu_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_ar", 32'(arvalid), 32'd1);
        chk("first_addr", araddr, RST_PC);

        fetch(32'h0010_0093, 2'b00, 0, 0, 0, 32'h3000_0004, 1'b0, 1'b0);
        fetch(32'h0020_0113, 2'b00, 2, 1, 5, 32'h3000_0008, 1'b0, 1'b0);
        fetch(32'hDEAD_BEEF, 2'b10, 0, 0, 0, 32'h3000_000C, 1'b0, 1'b0);
        fetch(32'h0030_0193, 2'b00, 0, 0, 0, 32'h3000_0010, 1'b0, 1'b0);
        fetch(32'h0040_0213, 2'b00, 1, 3, 1, 32'h3000_0100, 1'b0, 1'b1);
        fetch(32'h0050_0293, 2'b01, 0, 0, 2, 32'h3000_0102, 1'b1, 1'b0);
        fetch(32'h0060_0313, 2'b00, 0, 2, 0, 32'h3000_0200, 1'b1, 1'b0);

        // Reset while in R; a stale response afterwards must be dropped.
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("mid_r", 32'(rready), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'hBAD1_BAD1;
        rresp  = 2'b11;
        chk("mid_rst_pc", pc, RST_PC);
        chk("mid_rst_inst", inst, 32'h0);
        chk("mid_rst_ar", 32'(arvalid), 32'd0);
        chk("mid_rst_rr", 32'(rready), 32'd0);
        @(negedge clk);
        rvalid = 1'b0;
        rdata  = 32'h0;
        rresp  = 2'b00;
        chk("stale_inst", inst, 32'h0);
        chk("stale_fault", 32'(inst_fault), 32'd0);
        chk("post_rst_ar", 32'(arvalid), 32'd1);
        chk("post_rst_vld", 32'(ifu_valid), 32'd0);
        mpc = RST_PC;

        for (int k = 0; k < 12; k++) begin
            fetch($urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  RST_PC + 32'($urandom_range(0, 255)) * 4, 1'($urandom_range(0, 1)),
                  1'b0);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
